dmem_responder: RTL and testbench

Data-memory responder for the RV32I core's load/store port. It accepts one load or store request at a time over a valid/ready handshake, inserts a configurable number of wait states, and performs little-endian byte, halfword or word access on an internal word array. Loads are returned sign- or zero-extended; stores are written with byte-lane masking. It replaces the zero-latency data memory, so load/store benches exercise a stalling memory.

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_responder_lsu_lane_align.sv | 62 ++++++
 rtl/dmem_responder.sv | 185 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder: RV32I funct3 width codes,
// the responder FSM state encoding and a funct3 legality helper.
// Optional feature macro used by the block: DMEM_ALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

   // RV32I load/store width codes (funct3)
   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Stores only know B/H/W; loads add the unsigned byte/halfword forms.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) begin
         return (f3 <= F3_W);
      end
      return (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction

endpackage

// File: rtl/dmem_responder_lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Combinational little-endian lane logic for one 32-bit word.
//   funct3_i     : width code (B/H/W/BU/HU; anything else acts as word)
//   lane_i       : byte address bits [1:0]
//   old_word_i   : current contents of the addressed word
//   wdata_i      : right-aligned store data
//   load_data_o  : sign/zero-extended load result
//   store_word_o : old word with the store bytes merged in
//   misalign_o   : halfword on odd address or word on non-zero lane
// -----------------------------------------------------------------------------
module lsu_lane_align
   import dmem_responder_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] old_word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] store_word_o,
   output logic        misalign_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      byte_v       = old_word_i[8*lane_i +: 8];
      half_v       = lane_i[1] ? old_word_i[31:16] : old_word_i[15:0];
      load_data_o  = old_word_i;
      store_word_o = wdata_i;
      misalign_o   = 1'b0;

      case (funct3_i)
         F3_B:  load_data_o = {{24{byte_v[7]}}, byte_v};
         F3_BU: load_data_o = {24'd0, byte_v};
         F3_H:  load_data_o = {{16{half_v[15]}}, half_v};
         F3_HU: load_data_o = {16'd0, half_v};
         default: ;
      endcase

      case (funct3_i)
         F3_B: begin
            store_word_o                 = old_word_i;
            store_word_o[8*lane_i +: 8]  = wdata_i[7:0];
         end
         F3_H: begin
            store_word_o                     = old_word_i;
            store_word_o[16*lane_i[1] +: 16] = wdata_i[15:0];
         end
         default: ;
      endcase

      case (funct3_i)
         F3_H, F3_HU: misalign_o = lane_i[0];
         F3_W:        misalign_o = (lane_i != 2'b00);
         default:     misalign_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Stalling data memory for the RV32I load/store port. One request at a time
// over valid/ready, WAIT_STATES wait cycles, then a byte/half/word access on
// the internal word array dataArray and a held response.
//   clk, rst (sync, active-high)
//   req_valid/req_ready, req_we, req_funct3, req_addr, req_wdata : request
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err                      : response
// Macro DMEM_ALIGN_CHECK_EN: when defined, misalignment and illegal funct3
// raise rsp_err; when undefined, low address bits are masked, illegal funct3
// acts as word access and only out-of-range addresses raise rsp_err.
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [31:0] dataArray [DEPTH_WORDS];

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;

   // Access operands: live request when going straight from IDLE to RESP,
   // latched copy when coming out of WAIT.
   logic        acc_we;
   logic [2:0]  acc_f3;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic        acc_go;
   logic        acc_legal;
   logic        acc_oor;
   logic        acc_err;
   logic [2:0]  eff_f3;
   logic [1:0]  eff_lane;
   logic [IDX_W-1:0] mem_idx;
   logic [31:0] old_word;
   logic [31:0] load_data;
   logic [31:0] store_word;
   logic        misalign;
   logic [31:0] rdata_d;
   logic        mem_we;

   always_comb begin
      acc_we    = (state_q == ST_IDLE) ? req_we     : we_q;
      acc_f3    = (state_q == ST_IDLE) ? req_funct3 : f3_q;
      acc_addr  = (state_q == ST_IDLE) ? req_addr   : addr_q;
      acc_wdata = (state_q == ST_IDLE) ? req_wdata  : wdata_q;

      acc_go = ((state_q == ST_IDLE) && req_valid && (WAIT_STATES == 0)) ||
               ((state_q == ST_WAIT) && (cnt_q == 4'd0));

      acc_legal = f3_legal(acc_we, acc_f3);
      acc_oor   = (acc_addr[31:2] >= 30'(DEPTH_WORDS));

`ifdef DMEM_ALIGN_CHECK_EN
      eff_f3   = acc_f3;
      eff_lane = acc_addr[1:0];
`else
      // Illegal codes fall back to word access; the lane is aligned down to
      // the access size, so the sub-module's misalign flag can never fire.
      eff_f3 = acc_legal ? acc_f3 : F3_W;
      case (eff_f3)
         F3_H, F3_HU: eff_lane = {acc_addr[1], 1'b0};
         F3_W:        eff_lane = 2'b00;
         default:     eff_lane = acc_addr[1:0];
      endcase
`endif

      mem_idx  = acc_addr[IDX_W+1:2];
      old_word = dataArray[mem_idx];

`ifdef DMEM_ALIGN_CHECK_EN
      acc_err = !acc_legal || misalign || acc_oor;
`else
      acc_err = misalign || acc_oor;
`endif

      rdata_d = (acc_err || acc_we) ? 32'd0 : load_data;
      // A reset on the commit edge drops the store.
      mem_we  = acc_go && acc_we && !acc_err && !rst;
   end

   lsu_lane_align u_lane_align (
      .funct3_i     (eff_f3),
      .lane_i       (eff_lane),
      .old_word_i   (old_word),
      .wdata_i      (acc_wdata),
      .load_data_o  (load_data),
      .store_word_o (store_word),
      .misalign_o   (misalign)
   );

   // NOTE: the word array has no reset so it maps onto plain RAM and keeps
   // its preloaded contents across a core reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         dataArray[mem_idx] <= store_word;
      end
   end

   // NOTE: reset is sampled on the clock edge (synchronous) and all state
   // uses non-blocking assignments so every register updates together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         f3_q        <= 3'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (WAIT_STATES == 0) begin
                     state_q     <= ST_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= rdata_d;
                     rsp_err_q   <= acc_err;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= 4'(WAIT_STATES - 1);
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= rdata_d;
                  rsp_err_q   <= acc_err;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= 32'd0;
                  rsp_err_q   <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder (WAIT_STATES=2, DEPTH_WORDS=1024).
// Directed load/store/error/timing/reset steps, then random transactions,
// all compared against a byte-level reference memory model. Expected error
// behaviour follows DMEM_ALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int WS    = 2;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int errors = 0;
   int checks = 0;

   logic [31:0] ref_mem [DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: byte-addressed view of the spec rules.
   function automatic void model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rd, output logic e);
      int size, base, idx;
      bit legal;
      logic [31:0] w;
      idx = int'(addr >> 2);
      case (f3[1:0])
         2'd0:    size = 1;
         2'd1:    size = 2;
         2'd2:    size = 4;
         default: size = 0;
      endcase
      legal = we ? (f3 < 3) : !(f3 == 3 || f3 == 6 || f3 == 7);
`ifdef DMEM_ALIGN_CHECK_EN
      e = !legal;
      if (legal && (addr % size) != 0) e = 1'b1;
      base = int'(addr % 4);
`else
      if (!legal) size = 4;
      e = 1'b0;
      base = int'(addr % 4) - int'(addr % 4) % size;
`endif
      if (addr >= 32'(DEPTH * 4)) e = 1'b1;
      rd = 32'd0;
      if (e) return;
      if (we) begin
         for (int b = 0; b < size; b++)
            ref_mem[idx][8*(base+b) +: 8] = wdata[8*b +: 8];
      end else begin
         w = ref_mem[idx] >> (8 * base);
         if (size == 4) rd = w;
         else if (size == 2) begin
            rd = w & 32'h0000_FFFF;
            if (!f3[2] && w[15]) rd = rd | 32'hFFFF_0000;
         end else begin
            rd = w & 32'h0000_00FF;
            if (!f3[2] && w[7]) rd = rd | 32'hFFFF_FF00;
         end
      end
   endfunction

   // Wait (bounded) for rsp_valid, sampling 1 time unit after each edge.
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input string tag);
      logic [31:0] erd;
      logic        eerr;
      int          lat;
      model(we, f3, addr, wdata, erd, eerr);
      @(negedge clk);
      check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      rsp_ready  = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_rsp(lat);
      check({tag, " latency"}, 32'(lat), 32'(WS));
      check({tag, " rdata"}, rsp_rdata, erd);
      check({tag, " err"}, 32'(rsp_err), 32'(eerr));
      @(posedge clk); #1;
      check({tag, " req_ready after"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] erd, erd2;
      logic        eerr, eerr2;
      int          lat;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_rdata", rsp_rdata, 32'd0);
      check("reset rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Preload words 0..3 through the store port
      do_req(1'b1, 3'd2, 32'h0, 32'h0123_4567, "pre w0");
      do_req(1'b1, 3'd2, 32'h4, 32'h80F1_7F22, "pre w1");
      do_req(1'b1, 3'd2, 32'h8, 32'hCAFE_F00D, "pre w2");
      do_req(1'b1, 3'd2, 32'hC, 32'h7F80_01FF, "pre w3");

      // Byte, halfword and word loads
      do_req(1'b0, 3'd0, 32'h4, 32'h0, "LB 4");
      do_req(1'b0, 3'd0, 32'h7, 32'h0, "LB 7");
      do_req(1'b0, 3'd4, 32'h7, 32'h0, "LBU 7");
      do_req(1'b0, 3'd1, 32'h6, 32'h0, "LH 6");
      do_req(1'b0, 3'd5, 32'h6, 32'h0, "LHU 6");
      do_req(1'b0, 3'd2, 32'h4, 32'h0, "LW 4");

      // Stores with read-back
      do_req(1'b1, 3'd0, 32'h5, 32'h0000_00AB, "SB 5");
      do_req(1'b0, 3'd2, 32'h4, 32'h0, "LW after SB");
      do_req(1'b1, 3'd1, 32'h4, 32'h0000_1234, "SH 4");
      do_req(1'b0, 3'd2, 32'h4, 32'h0, "LW after SH");
      do_req(1'b1, 3'd2, 32'h4, 32'hDEAD_BEEF, "SW 4");
      do_req(1'b0, 3'd2, 32'h4, 32'h0, "LW after SW");
      do_req(1'b1, 3'd2, 32'h4, 32'h80F1_7F22, "SW restore");

      // Error / masking boundaries
      do_req(1'b0, 3'd2, 32'h6, 32'h0, "LW 6");
      do_req(1'b1, 3'd1, 32'h5, 32'h0000_5555, "SH 5");
      do_req(1'b0, 3'd2, 32'h4, 32'h0, "LW after SH 5");
      do_req(1'b0, 3'd3, 32'h4, 32'h0, "LD f3=3");
      do_req(1'b1, 3'd4, 32'h8, 32'h1111_2222, "store f3=4");
      do_req(1'b0, 3'd2, 32'h8, 32'h0, "LW after f3=4");
      do_req(1'b0, 3'd2, 32'h1000, 32'h0, "LW 0x1000");
      do_req(1'b0, 3'd2, 32'hFFC, 32'h0, "LW last word");

      // Held response, blocked second request, back-to-back accept
      model(1'b0, 3'd2, 32'h4, 32'h0, erd, eerr);
      @(negedge clk);
      rsp_ready  = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'd2;
      req_addr   = 32'h4;
      @(posedge clk); #1;
      req_funct3 = 3'd4;
      req_addr   = 32'h7;
      check("hold req_ready wait", 32'(req_ready), 32'd0);
      wait_rsp(lat);
      check("hold latency", 32'(lat), 32'(WS));
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("hold rsp_valid", 32'(rsp_valid), 32'd1);
         check("hold rsp_rdata", rsp_rdata, erd);
         check("hold req_ready", 32'(req_ready), 32'd0);
      end
      model(1'b0, 3'd4, 32'h7, 32'h0, erd2, eerr2);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("handshake rsp_valid", 32'(rsp_valid), 32'd0);
      check("handshake req_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("b2b accepted", 32'(req_ready), 32'd0);
      wait_rsp(lat);
      check("b2b latency", 32'(lat), 32'(WS));
      check("b2b rdata", rsp_rdata, erd2);
      check("b2b err", 32'(rsp_err), 32'(eerr2));
      @(posedge clk); #1;

      // Reset during WAIT of a store: store dropped
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = 32'h4;
      req_wdata  = 32'h0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      do_req(1'b0, 3'd2, 32'h4, 32'h0, "LW after rst");

      // Random traffic against the model
      for (int n = 0; n < 60; n++) begin
         logic        we;
         logic [2:0]  f3;
         logic [31:0] addr;
         we   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         addr = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 15))
                                            : 32'($urandom_range(0, 15));
         do_req(we, f3, addr, $urandom, "rand");
      end
      for (int k = 0; k < 4; k++)
         do_req(1'b0, 3'd2, 32'(4 * k), 32'h0, "final LW");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
